// File: rtl/sm4_pkg.sv
// sm4_pkg: shared SM4 constants, FSM state encoding and linear transforms
//   SBOX  - 256-entry byte substitution table
//   FK/CK - key-schedule system and fixed parameters
//   l_data / l_key - data-path L and key-schedule L' linear transforms
package sm4_pkg;

   typedef logic [1:0] sm4_state_t;

   localparam sm4_state_t S_IDLE   = 2'd0;
   localparam sm4_state_t S_KEYEXP = 2'd1;
   localparam sm4_state_t S_ROUND  = 2'd2;
   localparam sm4_state_t S_DONE   = 2'd3;

   localparam logic [31:0] FK [4] = '{32'ha3b1bac6, 32'h56aa3350, 32'h677d9197, 32'hb27022dc};

   localparam logic [31:0] CK [32] = '{
      32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
      32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
      32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
      32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
      32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
      32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
      32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
      32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279};

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48};

   function automatic logic [31:0] l_data(input logic [31:0] b);
      return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
   endfunction

   function automatic logic [31:0] l_key(input logic [31:0] b);
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

endpackage

// File: rtl/sm4_t_unit.sv
// sm4_t_unit: SM4 mixer T / T' (byte-wise S-box followed by L or L')
//   key_mode_i - 1 selects the key-schedule transform L', 0 the data transform L
//   a_i        - 32-bit input word
//   t_o        - transformed word
module sm4_t_unit
   import sm4_pkg::*;
(
   input  logic        key_mode_i,
   input  logic [31:0] a_i,
   output logic [31:0] t_o
);

   logic [31:0] b;

   assign b   = {SBOX[a_i[31:24]], SBOX[a_i[23:16]], SBOX[a_i[15:8]], SBOX[a_i[7:0]]};
   assign t_o = key_mode_i ? l_key(b) : l_data(b);

endmodule

// File: rtl/sm4_decrypt.sv
// sm4_decrypt: iterative SM4 block decryption, one round or key-schedule step per cycle
//   CLK, RST          - clock, asynchronous active-high reset
//   SM4_EN            - start request, accepted in IDLE or DONE
//   IN_DATA, IN_KEY   - ciphertext block and user key, word 0 in bits [127:96]
//   OUT_DATA          - plaintext, held until the next accepted request
//   OUT_READY         - plaintext valid level
//   BUSY              - key expansion or rounds in progress
module sm4_decrypt
   import sm4_pkg::*;
#(
   parameter int KEY_REUSE = 1
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         SM4_EN,
   input  logic [127:0] IN_DATA,
   input  logic [127:0] IN_KEY,
   output logic [127:0] OUT_DATA,
   output logic         OUT_READY,
   output logic         BUSY
);

   sm4_state_t   state_q, state_d;
   logic [4:0]   cnt_q, cnt_d;
   logic         key_valid_q, key_valid_d;
   logic [127:0] out_data_q, out_data_d;
   logic         out_ready_q, out_ready_d;
   logic [127:0] mk_q;
   logic [31:0]  x_q [4];
   logic [31:0]  k_q [4];
   logic [31:0]  rk_q [32];
   logic         accept, hit, in_kexp, in_round, last;
   logic [31:0]  t_in, t_out, new_k, new_x;

   assign in_kexp  = state_q == S_KEYEXP;
   assign in_round = state_q == S_ROUND;
   assign accept   = (state_q == S_IDLE || state_q == S_DONE) && SM4_EN;
   // mk_q only changes on an accept that also clears key_valid, so while
   // key_valid is set mk_q is exactly the key held in the round-key file
   assign hit      = (KEY_REUSE != 0) && key_valid_q && (IN_KEY == mk_q);
   assign last     = cnt_q == 5'd31;
   // decryption consumes round keys in reverse: 31 - cnt is ~cnt for 5 bits
   assign t_in     = in_kexp ? (k_q[1] ^ k_q[2] ^ k_q[3] ^ CK[cnt_q])
                             : (x_q[1] ^ x_q[2] ^ x_q[3] ^ rk_q[~cnt_q]);
   assign new_k    = k_q[0] ^ t_out;
   assign new_x    = x_q[0] ^ t_out;

   sm4_t_unit u_t (
      .key_mode_i (in_kexp),
      .a_i        (t_in),
      .t_o        (t_out)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      key_valid_d = key_valid_q;
      out_data_d  = out_data_q;
      out_ready_d = out_ready_q;
      if (accept) begin
         state_d     = hit ? S_ROUND : S_KEYEXP;
         cnt_d       = 5'd0;
         key_valid_d = hit;
         out_ready_d = 1'b0;
      end else if (in_kexp) begin
         cnt_d       = cnt_q + 5'd1;
         state_d     = last ? S_ROUND : S_KEYEXP;
         key_valid_d = last;
      end else if (in_round) begin
         cnt_d       = cnt_q + 5'd1;
         state_d     = last ? S_DONE : S_ROUND;
         out_ready_d = last;
         out_data_d  = last ? {new_x, x_q[3], x_q[2], x_q[1]} : out_data_q;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= 5'd0;
         key_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         key_valid_q <= key_valid_d;
         out_data_q  <= out_data_d;
         out_ready_q <= out_ready_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (accept) begin
         mk_q <= IN_KEY;
         for (int i = 0; i < 4; i++) begin
            x_q[i] <= IN_DATA[127-32*i -: 32];
            k_q[i] <= IN_KEY[127-32*i -: 32] ^ FK[i];
         end
      end else if (in_kexp) begin
         rk_q[cnt_q] <= new_k;
         k_q[0]      <= k_q[1];
         k_q[1]      <= k_q[2];
         k_q[2]      <= k_q[3];
         k_q[3]      <= new_k;
      end else if (in_round) begin
         x_q[0] <= x_q[1];
         x_q[1] <= x_q[2];
         x_q[2] <= x_q[3];
         x_q[3] <= new_x;
      end
   end

   assign OUT_DATA  = out_data_q;
   assign OUT_READY = out_ready_q;
   assign BUSY      = in_kexp || in_round;

endmodule

// File: doc/sm4_decrypt.md
SM4_DECRYPT -- requirements
Module: sm4_decrypt

Interface
REQ-001 Parameter KEY_REUSE, default 1: when 1, key expansion is skipped if the captured key equals the last fully expanded key.
REQ-002 CLK  input  1  single clock; all state updates on its rising edge.
REQ-003 RST  input  1  reset, asynchronous and active-high.
REQ-004 SM4_EN  input  1  start request, sampled on a rising edge.
REQ-005 IN_DATA  input  128  ciphertext block; word 0 is bits [127:96].
REQ-006 IN_KEY  input  128  user key MK; MK0 is bits [127:96].
REQ-007 OUT_DATA  output  128  plaintext; same word order as IN_DATA.
REQ-008 OUT_READY  output  1  plaintext valid (level signal).
REQ-009 BUSY  output  1  high while in KEYEXP or ROUND.

Function
REQ-010 FSM states: IDLE, KEYEXP, ROUND, DONE.
REQ-011 In IDLE or DONE, SM4_EN=1 at an edge shall capture IN_DATA and IN_KEY and clear OUT_READY on that edge (the accepting edge).
REQ-012 From the accepting edge, the next state shall be ROUND if KEY_REUSE=1 and the key is valid and matches; otherwise it shall be KEYEXP.
REQ-013 KEYEXP shall run 32 cycles: K = MK xor FK; rk[i] = K[i] xor T'(K[i+1]^K[i+2]^K[i+3]^CK[i]), where T' uses L'(B)=B^(B<<<13)^(B<<<23); rk[i] is stored in a 32x32 register file; the state then goes to ROUND.
REQ-014 ROUND shall run 32 cycles; round j computes X[j+4] = X[j] xor T(X[j+1]^X[j+2]^X[j+3]^rk[31-j]), where T uses L(B)=B^(B<<<2)^(B<<<10)^(B<<<18)^(B<<<24).
REQ-015 On the 32nd ROUND edge: OUT_DATA = {X35,X34,X33,X32}, OUT_READY=1, state goes to DONE.
REQ-016 Latency, accepting edge to OUT_READY high: 64 edges with key expansion; 32 edges on key reuse.
REQ-017 In DONE, OUT_READY and OUT_DATA shall hold until the next accepting edge.
REQ-018 SM4_EN, IN_DATA and IN_KEY shall be ignored while BUSY=1; no queuing.
REQ-019 In DONE, SM4_EN=1 shall start a new operation on that edge; OUT_READY falls on the same edge and OUT_DATA keeps its old value until the new result is written.
REQ-020 The key-valid flag shall be set only when KEYEXP completes all 32 cycles.
REQ-021 All XOR and rotate operations shall be 32-bit modular; round and key counters shall be 5-bit and wrap 31->0 at the state exit.

Reset
REQ-022 RST=1 shall immediately force: state IDLE, OUT_DATA=0, OUT_READY=0, BUSY=0, counters 0, key-valid flag 0.
REQ-023 RST asserted mid-KEYEXP or mid-ROUND shall abort the operation; after release, the first accepting edge shall perform a full key expansion.
REQ-024 Round-key register file and data registers need no reset; they are never observable before being written.

Structure
REQ-025 Shared package sm4_pkg shall hold: SBOX[256], FK[4], CK[32], the FSM state typedef, and the L/L' rotation functions; the encryption core shall use the same package.
REQ-026 One sub-module, sm4_t_unit: four S-box lookups plus mode-selected L or L' linear transform; one instance shared between KEYEXP and ROUND.

Verification
REQ-027 Standard vector: key 0123456789abcdeffedcba9876543210, IN_DATA 681edf34d206965e86b3e94f536e4246 -> OUT_DATA 0123456789abcdeffedcba9876543210, OUT_READY high exactly 64 edges after acceptance.
REQ-028 Same key repeated, KEY_REUSE=1 -> identical plaintext, latency 32 edges; with KEY_REUSE=0 -> latency 64 edges.
REQ-029 SM4_EN pulsed, with IN_DATA/IN_KEY changed to all-ones at ROUND cycle 10 -> result still 0123456789abcdeffedcba9876543210 and BUSY never drops early.
REQ-030 RST pulsed at KEYEXP cycle 20, then the standard vector is restarted -> OUT_READY=0 and OUT_DATA=0 during reset; correct plaintext after 64 edges (no reuse).
REQ-031 SM4_EN held high continuously -> back-to-back operations; OUT_READY is high for exactly one cycle in each DONE and OUT_DATA is correct each time.
REQ-032 Round trip against the encryption core, 1000 random key/data pairs -> decrypt(encrypt(P)) = P.
